vga_scan_gen: RTL and testbench

Raster scan generator that produces the pixel coordinates (x, y) consumed by the glyph and sprite renderers, together with VGA hsync, vsync and video_on.
- Default timing is 640x480 at 60 Hz from a 100 MHz system clock with a 25 MHz pixel tick.
- Sits between the board clock and every renderer and pixel mux in the pong display path.

---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/pixel_tick_div.sv | 43 ++++
 rtl/vga_scan_gen.sv | 115 +++++++++++
 tb/tb_vga_scan_gen.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and coordinate width,
// used by the scan generator and by the renderers for screen bounds.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int scan_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  localparam int H_TOTAL = scan_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int V_TOTAL = scan_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/pixel_tick_div.sv
// System-clock to pixel-tick divider. adv marks the edge on which the scan
// counters step; pixel_tick is the registered strobe seen by the renderers.
module pixel_tick_div
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic adv,
  output logic pixel_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
    adv    = en && (cnt_q == LAST);
    // strobe is high for the clk in which the count sits at its last value
    tick_d = en && (cnt_d == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign pixel_tick = tick_q;

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator: pixel coordinates plus hsync/vsync/video_on.
// Define SCAN_PIPE_EN to delay the sync/video decode by one pixel.
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               pixel_tick,
  output logic               frame_start
);

  localparam int H_TOT = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_TOT - 1);
  localparam logic [COORD_W-1:0] X_VIS  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] Y_VIS  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_LO  = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_HI  = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_LO  = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_HI  = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  // {hsync, vsync, video_on} for one coordinate
  function automatic logic [2:0] decode(input logic [COORD_W-1:0] xx,
                                        input logic [COORD_W-1:0] yy);
    logic hs, vs, vid;
    hs  = !((xx >= HS_LO) && (xx < HS_HI));
    vs  = !((yy >= VS_LO) && (yy < VS_HI));
    vid = (xx < X_VIS) && (yy < Y_VIS);
    return {hs, vs, vid};
  endfunction

  logic               adv;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               fs_q, fs_d;
  logic [2:0]         dec_q, dec_d;

  pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .adv        (adv),
    .pixel_tick (pixel_tick)
  );

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    fs_d = 1'b0;
    if (adv) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d  = '0;
          fs_d = 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

`ifdef SCAN_PIPE_EN
  // stage captures the pixel being left, so the decode trails x/y by one pixel
  always_comb begin
    dec_d = adv ? decode(x_q, y_q) : dec_q;
  end
`else
  // decode of the next coordinate lands on the same edge as x/y
  always_comb begin
    dec_d = decode(x_d, y_d);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      fs_q  <= 1'b0;
      dec_q <= 3'b110;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      fs_q  <= fs_d;
      dec_q <= dec_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign hsync       = dec_q[2];
  assign vsync       = dec_q[1];
  assign video_on    = dec_q[0];

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen on a shrunken raster; expected outputs come
// from an arithmetic model based on the count of enabled clocks since reset.
module tb_vga_scan_gen;

  localparam int D  = 3;
  localparam int HA = 20, HF = 2, HS = 3, HB = 2;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic       clk, rst_n, en;
  logic [9:0] x, y;
  logic       hsync, vsync, video_on, pixel_tick, frame_start;

  vga_scan_gen #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .y(y),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pixel_tick(pixel_tick), .frame_start(frame_start)
  );

  typedef struct {
    int x, y, hs, vs, vid, pt, fs;
  } exp_t;

  exp_t        exp_q[$];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int unsigned e_cnt   = 0;
  int          cur_x   = 0;
  int          cur_y   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input int act, input int expv);
    vec_cnt++;
    if (act != expv) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic exp_t ref_dec(input int px, input int py, input exp_t r);
    exp_t o = r;
    o.hs  = (px >= HA + HF && px < HA + HF + HS) ? 0 : 1;
    o.vs  = (py >= VA + VF && py < VA + VF + VS) ? 0 : 1;
    o.vid = (px < HA && py < VA) ? 1 : 0;
    return o;
  endfunction

  // One posedge of the reference: pixel index = enabled clocks / D
  task automatic model_step(output exp_t r);
    int p;
    r = '{x: 0, y: 0, hs: 1, vs: 1, vid: 0, pt: 0, fs: 0};
    if (!rst_n) begin
      e_cnt = 0;
    end else begin
      if (en) e_cnt++;
      p    = int'(e_cnt / D);
      r.x  = p % HT;
      r.y  = (p / HT) % VT;
      r.pt = (en && (e_cnt % D == D - 1)) ? 1 : 0;
      r.fs = (en && (e_cnt % D == 0) && (p % (HT * VT) == 0)) ? 1 : 0;
`ifdef SCAN_PIPE_EN
      if (p > 0) r = ref_dec((p - 1) % HT, ((p - 1) / HT) % VT, r);
`else
      r = ref_dec(r.x, r.y, r);
`endif
    end
    cur_x = r.x;
    cur_y = r.y;
  endtask

  task automatic run_clk();
    exp_t r;
    @(posedge clk);
    model_step(r);
    exp_q.push_back(r);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("x",           int'(x),           e.x);
        chk("y",           int'(y),           e.y);
        chk("hsync",       int'(hsync),       e.hs);
        chk("vsync",       int'(vsync),       e.vs);
        chk("video_on",    int'(video_on),    e.vid);
        chk("pixel_tick",  int'(pixel_tick),  e.pt);
        chk("frame_start", int'(frame_start), e.fs);
      end
    end
  end

  initial begin
    int guard;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) run_clk();
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (200) run_clk();

    // pause mid-line inside the visible area
    guard = 0;
    while (cur_x != 12 && guard < 2000) begin
      run_clk();
      guard++;
    end
    chk("reach_pause_point", cur_x, 12);
    en = 1'b0;
    repeat (37) run_clk();
    en = 1'b1;
    repeat (50) run_clk();

    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 99) < 85);
      run_clk();
    end

    // async reset while inside both sync pulses
    en    = 1'b1;
    guard = 0;
    while (!(cur_x == HA + HF + 1 && cur_y == VA + VF + 1) && guard < 6000) begin
      run_clk();
      guard++;
    end
    chk("reach_reset_point", cur_x * 1000 + cur_y, (HA + HF + 1) * 1000 + VA + VF + 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_x",           int'(x),           0);
    chk("async_rst_y",           int'(y),           0);
    chk("async_rst_hsync",       int'(hsync),       1);
    chk("async_rst_vsync",       int'(vsync),       1);
    chk("async_rst_video_on",    int'(video_on),    0);
    chk("async_rst_pixel_tick",  int'(pixel_tick),  0);
    chk("async_rst_frame_start", int'(frame_start), 0);
    @(negedge clk);
    repeat (2) run_clk();
    rst_n = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 99) < 95);
      run_clk();
    end

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
